// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue and drain into idle cycles.
// Optional macro WB_BYPASS_EN lets an ll result skip the empty FIFO and write in the same cycle.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_regwrite,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  input  logic                     ll_valid,
  output logic                     ll_ready,
  input  logic [4:0]               ll_rd,
  input  logic [31:0]              ll_data,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [31:0]              rf_data,
  output logic                     stall_req,
  input  logic [4:0]               query_rd,
  output logic                     query_hit,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, idx;
  logic [AW:0]   count;
  logic [SW-1:0] starve, starve_next;
  logic          pipe_active, fifo_empty, pop, push, bypass, stall_next;

  always_comb begin
    fifo_empty  = (count == (AW+1)'(0));
    pipe_active = pipe_regwrite && (pipe_rd != 5'd0) && !stall_req;
    ll_ready    = (count < DEPTH_C);
    bypass      = 1'b0;
`ifdef WB_BYPASS_EN
    bypass      = fifo_empty && !pipe_active && ll_valid && (ll_rd != 5'd0);
`endif
    pop         = !pipe_active && !fifo_empty;
    push        = ll_valid && ll_ready && (ll_rd != 5'd0) && !bypass;
    rf_we       = 1'b0;
    rf_rd       = 5'd0;
    rf_data     = 32'd0;
    if (pipe_active) begin
      rf_we   = 1'b1;
      rf_rd   = pipe_rd;
      rf_data = pipe_data;
    end else if (!fifo_empty) begin
      rf_we   = 1'b1;
      rf_rd   = mem_rd[rd_ptr];
      rf_data = mem_data[rd_ptr];
    end else if (bypass) begin
      rf_we   = 1'b1;
      rf_rd   = ll_rd;
      rf_data = ll_data;
    end else begin
      rf_we   = 1'b0;
    end
    if (rst) begin
      rf_we = 1'b0;
    end else begin
      rf_we = rf_we;
    end
  end

  // Starvation counter saturates; stall is raised on the edge the counter reaches the limit.
  always_comb begin
    if (fifo_empty || pop) begin
      starve_next = SW'(0);
    end else if (starve == LIMIT_C) begin
      starve_next = LIMIT_C;
    end else begin
      starve_next = starve + 1'b1;
    end
    stall_next = !stall_req && (starve_next == LIMIT_C);
  end

  always_comb begin
    query_hit = 1'b0;
    idx       = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (((AW+1)'(i) < count) && (mem_rd[idx] == query_rd)) begin
        query_hit = 1'b1;
      end else begin
        query_hit = query_hit;
      end
    end
    if (query_rd == 5'd0) begin
      query_hit = 1'b0;
    end else begin
      query_hit = query_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= AW'(0);
      rd_ptr    <= AW'(0);
      count     <= (AW+1)'(0);
      starve    <= SW'(0);
      stall_req <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      starve    <= starve_next;
      stall_req <= stall_next;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= ll_rd;
      mem_data[wr_ptr] <= ll_data;
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized self-checking bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_regwrite, ll_valid, ll_ready, rf_we, stall_req, query_hit;
  logic [4:0]  pipe_rd, ll_rd, rf_rd, query_rd;
  logic [31:0] pipe_data, ll_data, rf_data;
  logic [2:0]  fifo_count;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .pipe_regwrite(pipe_regwrite), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .stall_req(stall_req),
    .query_rd(query_rd), .query_hit(query_hit), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t q[$];
  int   starve_m;
  bit   stall_m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle: compare the DUT with the model, then advance the model across the coming edge.
  task automatic settle();
    bit pa, byp, hit, popped, acc;
    int n;
    ent_t e;
    #4;
    if (rst) begin
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      chk("rst_ll_ready", 32'(ll_ready), 32'd1);
      q.delete();
      starve_m = 0;
      stall_m  = 1'b0;
      return;
    end
    n   = q.size();
    pa  = pipe_regwrite && (pipe_rd != 5'd0) && !stall_m;
    byp = 1'b0;
`ifdef WB_BYPASS_EN
    byp = (n == 0) && !pa && ll_valid && (ll_rd != 5'd0);
`endif
    if (pa) begin
      chk("rf_we", 32'(rf_we), 32'd1);
      chk("rf_rd", 32'(rf_rd), 32'(pipe_rd));
      chk("rf_data", rf_data, pipe_data);
    end else if (n > 0) begin
      chk("rf_we", 32'(rf_we), 32'd1);
      chk("rf_rd", 32'(rf_rd), 32'(q[0].rd));
      chk("rf_data", rf_data, q[0].data);
    end else if (byp) begin
      chk("rf_we", 32'(rf_we), 32'd1);
      chk("rf_rd", 32'(rf_rd), 32'(ll_rd));
      chk("rf_data", rf_data, ll_data);
    end else begin
      chk("rf_we", 32'(rf_we), 32'd0);
      chk("rf_rd", 32'(rf_rd), 32'd0);
      chk("rf_data", rf_data, 32'd0);
    end
    hit = 1'b0;
    foreach (q[i]) if (q[i].rd == query_rd) hit = 1'b1;
    if (query_rd == 5'd0) hit = 1'b0;
    chk("ll_ready", 32'(ll_ready), 32'(n < DEPTH));
    chk("stall_req", 32'(stall_req), 32'(stall_m));
    chk("fifo_count", 32'(fifo_count), 32'(n));
    chk("query_hit", 32'(query_hit), 32'(hit));
    popped = !pa && (n > 0);
    acc    = ll_valid && (n < DEPTH);
    if (popped) void'(q.pop_front());
    if (acc && (ll_rd != 5'd0) && !byp) begin
      e.rd = ll_rd;
      e.data = ll_data;
      q.push_back(e);
    end
    if (n == 0 || popped) starve_m = 0;
    else if (starve_m < LIMIT) starve_m = starve_m + 1;
    stall_m = !stall_m && (starve_m == LIMIT);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b1; pipe_regwrite = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0; query_rd = 5'd0;
    settle();
    tick();
    rst = 1'b0;
    settle();
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_ll_ready", 32'(ll_ready), 32'd1);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);
    tick();

    ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 32'hDEADBEEF;
    settle();
`ifdef WB_BYPASS_EN
    chk("bypass_we", 32'(rf_we), 32'd1);
    chk("bypass_rd", 32'(rf_rd), 32'd5);
`else
    chk("ll_first_we", 32'(rf_we), 32'd0);
`endif
    tick();
    ll_valid = 1'b0;
    settle();
`ifndef WB_BYPASS_EN
    chk("ll_drain_we", 32'(rf_we), 32'd1);
    chk("ll_drain_rd", 32'(rf_rd), 32'd5);
    chk("ll_drain_data", rf_data, 32'hDEADBEEF);
    chk("ll_drain_count", 32'(fifo_count), 32'd1);
`endif
    tick();
    settle();
    chk("ll_after_count", 32'(fifo_count), 32'd0);
    chk("ll_after_we", 32'(rf_we), 32'd0);
    tick();

    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h1234;
    settle();
    chk("rd0_ready", 32'(ll_ready), 32'd1);
    tick();
    ll_valid = 1'b0;
    settle();
    chk("rd0_we", 32'(rf_we), 32'd0);
    chk("rd0_count", 32'(fifo_count), 32'd0);
    tick();

    pipe_regwrite = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    for (int k = 0; k < 4; k++) begin
      ll_valid = 1'b1; ll_rd = 5'(6 + k); ll_data = 32'h600 + 32'(k);
      settle();
      tick();
    end
    ll_valid = 1'b0; query_rd = 5'd8;
    settle();
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(ll_ready), 32'd0);
    chk("query_8", 32'(query_hit), 32'd1);
    chk("pipe_wins", 32'(rf_rd), 32'd3);
    query_rd = 5'd13; #1;
    chk("query_13", 32'(query_hit), 32'd0);
    query_rd = 5'd0; #1;
    chk("query_0", 32'(query_hit), 32'd0);
    tick();

    for (i = 0; i < 20; i++) begin
      settle();
      if (stall_req) break;
      tick();
    end
    chk("stall1_delay", 32'(i), 32'd4);
    chk("stall1_rd", 32'(rf_rd), 32'd6);
    chk("stall1_data", rf_data, 32'h600);
    tick();
    for (i = 0; i < 20; i++) begin
      settle();
      if (stall_req) break;
      tick();
    end
    chk("stall2_period", 32'(i), 32'd8);
    chk("stall2_rd", 32'(rf_rd), 32'd7);
    chk("stall2_count", 32'(fifo_count), 32'd3);
    rst = 1'b1; #1;
    chk("async_count", 32'(fifo_count), 32'd0);
    chk("async_stall", 32'(stall_req), 32'd0);
    chk("async_we", 32'(rf_we), 32'd0);
    rst = 1'b0;
    q.delete(); starve_m = 0; stall_m = 1'b0;
    tick();

    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      pipe_regwrite = ($urandom_range(0, 2) != 0);
      pipe_rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_data     = $urandom;
      ll_valid      = $urandom_range(0, 1) == 1;
      ll_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      ll_data       = $urandom;
      query_rd      = 5'($urandom_range(0, 15));
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (pipe_*) and a long-latency unit (ll_*, e.g. mul/div).
- The pipeline has priority. Long-latency results queue in a small FIFO and drain into idle port cycles.
- A starvation counter can request a one-cycle pipeline stall to force a drain.
- Sits between the WB stage outputs and the regfile write port. The hazard unit uses its query port.

Parameters:
- DEPTH, 4: FIFO entries for long-latency results (power of 2, >=2).
- STARVE_LIMIT, 8: consecutive non-draining cycles with FIFO non-empty before stall_req asserts (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pipe_regwrite  in  1  pipeline WB write enable.
- pipe_rd  in  5  pipeline WB destination.
- pipe_data  in  32  pipeline WB data.
- ll_valid  in  1  long-latency result valid.
- ll_ready  out  1  arbiter can accept ll result.
- ll_rd  in  5  ll destination.
- ll_data  in  32  ll data.
- rf_we  out  1  regfile write enable.
- rf_rd  out  5  regfile write address.
- rf_data  out  32  regfile write data.
- stall_req  out  1  registered request for the pipeline to stall WB one cycle.
- query_rd  in  5  hazard-check register.
- query_hit  out  1  query_rd pending in FIFO.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset: FIFO empty, fifo_count=0, starve counter=0, stall_req=0. rf_we forced 0 while rst=1. ll_ready=1 after reset.
- pipe_active = pipe_regwrite && pipe_rd!=0 && !stall_req.
- Port grant (combinational, same cycle):
  - If pipe_active: rf_* = pipe_*, rf_we=1.
  - Else if FIFO non-empty: rf_* = head, rf_we=1, head popped at clock edge.
  - Else rf_we=0, rf_rd=0, rf_data=0.
- stall_req=1 cycle: pipe inputs ignored. The pipeline guarantees to re-present them next cycle. The FIFO head is granted if present.
- ll handshake: ll_ready = (fifo_count < DEPTH), independent of the same-cycle pop.
  - Transfer when ll_valid && ll_ready. Entry pushed at the edge; earliest write is the next cycle (1-cycle latency).
  - ll_rd==0 is accepted (handshake completes) but not pushed.
- Simultaneous push and pop: count unchanged, order preserved (strict FIFO). Duplicate rd entries are written in arrival order.
- Pointers wrap modulo DEPTH. Full: ll_ready=0, ll_valid holds. Empty: no pop.
- Starve counter:
  - Increments each cycle FIFO non-empty and no pop occurs, saturating at STARVE_LIMIT.
  - Clears to 0 on pop or when empty.
  - stall_req is registered: set to 1 at the edge where the counter equals STARVE_LIMIT. Cleared at the edge of the cycle in which it was 1 (that cycle pops the head).
- query_hit = query_rd!=0 && any valid FIFO entry rd==query_rd. Combinational over stored entries only; excludes the same-cycle ll input.
- Async rst mid-operation: all queued entries discarded immediately, stall_req=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when FIFO empty, !pipe_active and ll_valid with ll_rd!=0, the ll result goes straight to rf_* in the same cycle. No push, ll_ready=1, zero latency; starve counter unaffected.
- Undefined: every ll result goes through the FIFO, so minimum 1-cycle latency.

Test Plan:
- Reset, idle inputs -> rf_we=0, ll_ready=1, fifo_count=0, stall_req=0.
- ll_valid rd=5 data=0xDEADBEEF, pipe idle -> next cycle rf_we=1 rd=5 data=0xDEADBEEF, fifo_count back to 0. With WB_BYPASS_EN: write in the same cycle.
- pipe_regwrite rd=3 continuously, 4 ll pushes rd=6..9 -> ll_ready=0 at count 4. stall_req=1 exactly once per STARVE_LIMIT(8)+1 cycles. During stall_req, the rf write is the FIFO head in order 6,7,8,9.
- Push at full count while popping -> ll_ready=0, no overflow. Count stays correct across pointer wrap over 10 push/pop cycles.
- FIFO holds rd=12, query_rd=12 -> query_hit=1. query_rd=0 or 13 -> 0. ll rd=0 accepted, never written.
- Assert rst with 3 entries queued and stall_req=1 -> immediately fifo_count=0, stall_req=0, rf_we=0.
